gnt_watchdog: RTL
=================

# gnt_watchdog

Multi-channel grant tracker with deadlock detection: parametrised successor to the single-channel IDLE/ACTIVE grant tracker. One tracker per grant channel follows the grant through IDLE/ACTIVE and flags STUCK when a grant is held for more than TIMEOUT consecutive cycles. Sits beside the arbiter, with outputs feeding the status/interrupt block. Turns the bench-only deadlock check into synthesizable, sticky, software-clearable hardware status.

## Interface
- NUM_CH, 4: number of grant channels, ≥1
- TIMEOUT, 7: cycles a grant may stay in ACTIVE before STUCK, ≥1
- STICKY, 1: 1 = STUCK held until `clr`; 0 = STUCK self-clears when gnt drops
- EVT_W, 8: width of saturating stuck-event counter
- Derived: CNT_W = $clog2(TIMEOUT+1); ID_W = max(1, $clog2(NUM_CH))

- clk  in  1  clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- gnt  in  NUM_CH  per-channel grant, sampled on clk
- clr  in  NUM_CH  per-channel STUCK clear, single-cycle pulse
- active  out  NUM_CH  channel state is ACTIVE or STUCK
- stuck  out  NUM_CH  channel state is STUCK
- stuck_any  out  1  OR of stuck
- first_vld  out  1  first_id valid
- first_id  out  ID_W  index of the recorded stuck channel
- evt_cnt  out  EVT_W  saturating count of STUCK entries

## Operation
- Per-channel FSM states: IDLE, ACTIVE, STUCK. Each channel has a cnt of CNT_W bits.
- IDLE:
  - gnt=1 → ACTIVE, cnt←0.
  - Otherwise stay.
- ACTIVE:
  - gnt=0 → IDLE, cnt←0.
  - gnt=1 and cnt==TIMEOUT-1 → STUCK.
  - Otherwise cnt←cnt+1.
- STUCK, STICKY=1:
  - clr=1 → ACTIVE (cnt←0) if gnt=1, else IDLE.
  - clr=0 → stay, regardless of gnt.
- STUCK, STICKY=0:
  - gnt=0 → IDLE; clr is ignored.
- clr is ignored in IDLE and ACTIVE.
- cnt never exceeds TIMEOUT-1; no wrap.
- First-stuck capture, computed from next-state stuck vector S:
  - first_vld ← |S.
  - If first_vld=1 and S[first_id]=1, first_id holds.
  - Otherwise first_id ← lowest set index of S (0 when S==0).
  - Simultaneous entries: lowest index wins.
  - When the recorded channel clears while others remain stuck, first_id moves to the lowest remaining stuck index on the same edge.
- evt_cnt:
  - Each cycle, add the number of channels entering STUCK on that edge (popcount, up to NUM_CH).
  - Saturate at 2^EVT_W-1; never wraps.
  - Cleared only by reset.

## Timing
- All outputs are registered and derived from state registers; no combinational path from gnt or clr to any output.
- Reset (reset_n=0, asynchronous assert):
  - All channels IDLE, cnt=0.
  - active=0, stuck=0, stuck_any=0, first_vld=0, first_id=0, evt_cnt=0.
- Deassertion is synchronised externally.
- Reset mid-operation discards all state, including sticky STUCK.
- Latency:
  - gnt sampled 1 at edge E → active=1 after E.
  - gnt held 1 at edges E..E+TIMEOUT → stuck=1 after E+TIMEOUT.
  - Minimum TIMEOUT+1 consecutive high samples to reach STUCK.
- gnt dropping at edge E+TIMEOUT → IDLE after that edge, no STUCK. This is the boundary case.
- clr sampled at edge E → stuck=0 after E. first_vld and evt_cnt update on the same edge as stuck.
- Asserting clr and entering STUCK on the same edge is impossible (clr only acts in STUCK), so there is no conflict.

## Structure
- Package gnt_watchdog_pkg holds:
  - typedef enum logic [1:0] gw_state_t {GW_IDLE, GW_ACTIVE, GW_STUCK}
  - a popcount function
  - a lowest-set-index function
- Sub-module gnt_watchdog_ch, one per channel via generate:
  - Parameters TIMEOUT and STICKY.
  - Inputs clk, reset_n, gnt, clr.
  - Outputs state, active, stuck, plus a single-cycle enter_stuck for the popcount.
- Top level owns first-stuck capture, evt_cnt and stuck_any.
- Bench keeps the original assertion form, generalised per channel: state≠IDLE and $stable(state) for TIMEOUT+1 cycles implies stuck.

## Test plan
- Defaults; gnt[0] high 8 cycles from edge 0 → stuck[0]=1 after edge 7, first_vld=1, first_id=0, evt_cnt=1.
- gnt[1] high exactly 7 edges then low → active high 7 cycles, stuck never set, evt_cnt=0.
- gnt[3] and gnt[2] both reach STUCK on the same edge → first_id=2, evt_cnt=2. clr[2] with gnt[2]=0 → stuck[2]=0, first_id=3 on the same edge.
- STICKY=1: stuck[0] set, gnt[0] drops → stuck[0] stays 1. clr[0] while gnt[0]=1 → ACTIVE, restimeout after 7 more edges → evt_cnt increments.
- STICKY=0, TIMEOUT=1: gnt high 2 edges → STUCK; gnt low → IDLE next edge, clr ignored.
- EVT_W=2: five STUCK entries → evt_cnt saturates at 3. Assert reset_n mid-STUCK → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/gnt_watchdog_pkg.sv
// Shared types and helpers for the grant watchdog: channel state encoding plus
// popcount / lowest-set-index over a vector zero-extended to GW_MAX_CH bits.
package gnt_watchdog_pkg;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_ACTIVE = 2'd1,
    GW_STUCK  = 2'd2
  } gw_state_t;

  // Helpers operate on a fixed-width vector; NUM_CH must not exceed this.
  localparam int GW_MAX_CH = 32;

  function automatic int unsigned gw_popcount(input logic [GW_MAX_CH-1:0] v);
    gw_popcount = 0;
    for (int i = 0; i < GW_MAX_CH; i++) begin
      gw_popcount = gw_popcount + 32'(v[i]);
    end
  endfunction

  function automatic int unsigned gw_lowest(input logic [GW_MAX_CH-1:0] v);
    gw_lowest = 0;
    for (int i = GW_MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) gw_lowest = i[31:0];
    end
  endfunction

endpackage

// File: rtl/gnt_watchdog_ch.sv
// One grant channel tracker: IDLE/ACTIVE/STUCK, STUCK after TIMEOUT+1 high samples.
// Outputs registered state, 1-cycle update latency; no backpressure (pure observer).
module gnt_watchdog_ch
  import gnt_watchdog_pkg::*;
#(
  parameter int TIMEOUT = 7,
  parameter bit STICKY  = 1'b1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      gnt,
  input  logic      clr,
  output gw_state_t state,
  output logic      active,
  output logic      stuck,
  output logic      stuck_nxt,
  output logic      enter_stuck
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  gw_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= GW_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      GW_IDLE: begin
        if (gnt) begin
          state_nxt = GW_ACTIVE;
          cnt_nxt   = '0;
        end
      end
      GW_ACTIVE: begin
        if (!gnt) begin
          state_nxt = GW_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = GW_STUCK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      GW_STUCK: begin
        // Sticky mode waits for software; otherwise the grant dropping releases it.
        if (STICKY) begin
          if (clr) begin
            state_nxt = gnt ? GW_ACTIVE : GW_IDLE;
            cnt_nxt   = '0;
          end
        end else if (!gnt) begin
          state_nxt = GW_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = GW_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    active      = (state != GW_IDLE);
    stuck       = (state == GW_STUCK);
    stuck_nxt   = (state_nxt == GW_STUCK);
    enter_stuck = stuck_nxt & ~stuck;
  end

endmodule

// File: rtl/gnt_watchdog.sv
// Multi-channel grant watchdog with first-stuck capture and saturating event count.
// All status registered, 1-cycle latency from gnt/clr; no backpressure (observer only).
module gnt_watchdog
  import gnt_watchdog_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 7,
  parameter bit STICKY  = 1'b1,
  parameter int EVT_W   = 8,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] gnt,
  input  logic [NUM_CH-1:0] clr,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] stuck,
  output logic              stuck_any,
  output logic              first_vld,
  output logic [ID_W-1:0]   first_id,
  output logic [EVT_W-1:0]  evt_cnt
);

  gw_state_t         ch_state [NUM_CH];
  logic [NUM_CH-1:0] stuck_nxt;
  logic [NUM_CH-1:0] enter;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gnt_watchdog_ch #(
      .TIMEOUT (TIMEOUT),
      .STICKY  (STICKY)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .gnt         (gnt[i]),
      .clr         (clr[i]),
      .state       (ch_state[i]),
      .active      (active[i]),
      .stuck       (stuck[i]),
      .stuck_nxt   (stuck_nxt[i]),
      .enter_stuck (enter[i])
    );
  end

  always_comb begin
    stuck_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_state[i] == GW_STUCK) stuck_any = 1'b1;
    end
  end

  logic [5:0]       enter_pc;
  logic [EVT_W+5:0] evt_sum;
  logic [ID_W-1:0]  first_id_nxt;

  always_comb begin
    enter_pc = 6'(gw_popcount(GW_MAX_CH'(enter)));
    evt_sum  = (EVT_W+6)'(evt_cnt) + (EVT_W+6)'(enter_pc);
    // Keep the recorded channel while it is still stuck; otherwise take the lowest.
    if (first_vld && stuck_nxt[first_id]) first_id_nxt = first_id;
    else first_id_nxt = ID_W'(gw_lowest(GW_MAX_CH'(stuck_nxt)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_vld <= 1'b0;
      first_id  <= '0;
      evt_cnt   <= '0;
    end else begin
      first_vld <= |stuck_nxt;
      first_id  <= first_id_nxt;
      evt_cnt   <= (|evt_sum[EVT_W+5:EVT_W]) ? {EVT_W{1'b1}} : evt_sum[EVT_W-1:0];
    end
  end

endmodule
